ext_mem_port: RTL
=================

# ext_mem_port

Parametrised bridge between a single reqrsp-style request/response channel and a synchronous single-port SRAM, such as the external instruction/data memory behind the core complex AXI master path. It replaces fixed 32-bit, 1-cycle, offset-only memory glue with the following features:
- configurable data width, base address, window size and SRAM read latency;
- out-of-window error responses;
- a credit-controlled response FIFO that tolerates response back-pressure without losing data.

## Interface
Parameters:
- DATA_WIDTH, 32, data/strobe width in bits; power of two, ≥ 32.
- ADDR_WIDTH, 32, request address width.
- BASE_ADDR, 32'h0000_1000, byte address of the first SRAM word.
- MEM_BYTES, 32'h0002_0000, window size in bytes; power of two.
- RD_LATENCY, 1, SRAM read latency in cycles from mem_req_o to valid mem_rdata_i; range 1..4.
- RSP_DEPTH, 4, total response credits (pipeline + FIFO); must be ≥ 1. Full throughput needs ≥ RD_LATENCY+2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request accepted when q_valid_i && q_ready_o.
- q_addr_i  in  ADDR_WIDTH  byte address.
- q_write_i  in  1  1 = write, 0 = read.
- q_data_i  in  DATA_WIDTH  write data.
- q_strb_i  in  DATA_WIDTH/8  write byte strobes.
- p_valid_o  out  1  response valid.
- p_ready_i  in  1  response consumed when p_valid_o && p_ready_i.
- p_data_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- p_error_o  out  1  1 = address outside the window.
- mem_req_o  out  1  SRAM enable.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  $clog2(MEM_BYTES/(DATA_WIDTH/8))  SRAM word address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data.
- err_cnt_o  out  16  saturating count of out-of-window requests.

## Operation
- **Window check:** the request is in-window iff q_addr_i ≥ BASE_ADDR and (q_addr_i − BASE_ADDR) < MEM_BYTES. The subtraction is unsigned at ADDR_WIDTH+1 bits, and a borrow means out-of-window. The low $clog2(DATA_WIDTH/8) address bits are ignored; all accesses are word-aligned.
- **mem_* outputs:** driven combinationally from the accepted request. mem_req_o = handshake && in-window. mem_addr_o = (q_addr_i − BASE_ADDR) >> $clog2(DATA_WIDTH/8). mem_we_o = q_write_i. mem_be_o = q_strb_i for writes and all-ones for reads. mem_wdata_o = q_data_i. When mem_req_o = 0, the other mem_* outputs are don't-care.
- **Out-of-window request:** no SRAM access. A response with p_error_o = 1 and p_data_o = 0 is generated. err_cnt_o increments and saturates at 16'hFFFF.
- **Response pipeline:** every accepted request, whether read, write or error, enters a RD_LATENCY-stage shift register carrying {valid, is_read, error}. This keeps responses in strict request order.
- **FIFO push:** when the last stage is valid, one entry is pushed into the response FIFO. The entry holds mem_rdata_i for in-window reads and 0 otherwise, plus the error bit.
- **Credits:** credit_used = pipeline occupancy + FIFO count. q_ready_o = (credit_used < RSP_DEPTH), registered-state based. A pop in the same cycle does not free a credit until the next cycle. The FIFO therefore can never overflow.
- **Response output:** p_valid_o = FIFO non-empty. p_data_o and p_error_o come from the FIFO head. Simultaneous push and pop on the same cycle are both performed, and the count is unchanged.

## Timing
- Reset values: q_ready_o = 1 (RSP_DEPTH ≥ 1), p_valid_o = 0, p_data_o = 0, p_error_o = 0, mem_req_o = 0, err_cnt_o = 0. Pipeline and FIFO are empty.
- Handshake at cycle T → mem_req_o asserted in cycle T → mem_rdata_i sampled at the end of cycle T+RD_LATENCY → p_valid_o asserted from cycle T+RD_LATENCY+1. Total latency is RD_LATENCY+1.
- Back-to-back accepts: one per cycle while credits remain. With RSP_DEPTH ≥ RD_LATENCY+2 and p_ready_i held high, throughput is 1 per cycle indefinitely.
- p_valid_o, p_data_o and p_error_o stay stable until popped.
- Reset asserted mid-operation: all in-flight and queued responses are discarded immediately. An SRAM write already issued is not undone.

## Test plan
- **Single read:** read 0x0000_1004, SRAM returns 0xDEAD_BEEF at RD_LATENCY=1 → mem_addr_o=1, p_valid_o in cycle T+2, p_data_o=0xDEAD_BEEF, p_error_o=0.
- **Write then read:** write 0x0000_1008 with data 0x1234_5678, strb 4'b0011, then read the same address → mem_we_o=1, mem_be_o=4'b0011, write response data 0; the read returns the bench model value 0x0000_5678.
- **Window edges:** addr 0x0002_0FFC → in-window, mem_addr_o=0x7FFF. Addr 0x0002_1000 and addr 0x0000_0FFC → p_error_o=1, no mem_req_o, err_cnt_o=2.
- **Back-pressure:** 8 back-to-back reads with p_ready_i=0 → q_ready_o drops after 4 accepts. Release p_ready_i → 8 responses returned in order, none lost.
- **Full throughput:** RD_LATENCY=3, RSP_DEPTH=5, p_ready_i=1, 100 reads → one response per cycle after the 4-cycle latency, addresses matched in order.
- **Reset mid-burst:** rst_ni low with 3 responses queued → p_valid_o=0 and q_ready_o=1 immediately; no stale response appears after reset releases.

Source files
------------

// File: rtl/ext_mem_port.sv
// Bridge from a reqrsp request/response channel to a synchronous single-port SRAM.
// Window-checked addressing, fixed-latency read pipeline and a credit-limited response FIFO.
module ext_mem_port #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h0000_1000),
  parameter int unsigned            MEM_BYTES  = 32'h0002_0000,
  parameter int unsigned            RD_LATENCY = 1,
  parameter int unsigned            RSP_DEPTH  = 4,
  localparam int unsigned           BE_W       = DATA_WIDTH / 8,
  localparam int unsigned           MEM_AW     = $clog2(MEM_BYTES / BE_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  q_valid_i,
  output logic                  q_ready_o,
  input  logic [ADDR_WIDTH-1:0] q_addr_i,
  input  logic                  q_write_i,
  input  logic [DATA_WIDTH-1:0] q_data_i,
  input  logic [BE_W-1:0]       q_strb_i,
  output logic                  p_valid_o,
  input  logic                  p_ready_i,
  output logic [DATA_WIDTH-1:0] p_data_o,
  output logic                  p_error_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_W-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [15:0]           err_cnt_o
);

  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 2);
  localparam int unsigned LAST  = RD_LATENCY - 1;

  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [ADDR_WIDTH:0]   offset;
  logic                  in_window;
  logic                  handshake;
  logic                  unused_addr_bits;

  logic [RD_LATENCY-1:0] pv_q, pv_d, pr_q, pr_d, pe_q, pe_d;
  logic [DATA_WIDTH:0]   fifo_mem_q [RSP_DEPTH];
  logic [DATA_WIDTH:0]   push_entry;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d, pipe_cnt, credit_used;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic                  push, pop;

  // Borrow out of the widened subtraction flags addresses below the base.
  assign addr_aligned     = {q_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign unused_addr_bits = ^q_addr_i[OFF_W-1:0];
  assign offset           = {1'b0, addr_aligned} - {1'b0, BASE_ADDR};
  assign in_window        = !offset[ADDR_WIDTH] &&
                            (64'(offset[ADDR_WIDTH-1:0]) < 64'(MEM_BYTES));
  assign handshake        = q_valid_i && q_ready_o;

  assign mem_req_o   = handshake && in_window;
  assign mem_we_o    = q_write_i;
  assign mem_addr_o  = offset[OFF_W +: MEM_AW];
  assign mem_wdata_o = q_data_i;
  assign mem_be_o    = q_write_i ? q_strb_i : {BE_W{1'b1}};

  assign push       = pv_q[LAST];
  assign pop        = p_valid_o && p_ready_i;
  assign push_entry = {pe_q[LAST], (pr_q[LAST] && !pe_q[LAST]) ? mem_rdata_i : {DATA_WIDTH{1'b0}}};

  assign p_valid_o   = (fifo_cnt_q != '0);
  assign p_data_o    = p_valid_o ? fifo_mem_q[rd_ptr_q][DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign p_error_o   = p_valid_o && fifo_mem_q[rd_ptr_q][DATA_WIDTH];
  assign credit_used = pipe_cnt + fifo_cnt_q;
  assign q_ready_o   = (credit_used < CNT_W'(RSP_DEPTH));
  assign err_cnt_o   = err_cnt_q;

  always_comb begin
    pv_d     = '0;
    pr_d     = '0;
    pe_d     = '0;
    pipe_cnt = '0;
    pv_d[0]  = handshake;
    pr_d[0]  = !q_write_i;
    pe_d[0]  = !in_window;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pr_d[i] = pr_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
    for (int i = 0; i < RD_LATENCY; i++) begin
      pipe_cnt = pipe_cnt + CNT_W'(pv_q[i]);
    end
  end

  // Depth need not be a power of two, so pointers wrap explicitly.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    err_cnt_d  = err_cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (handshake && !in_window && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q       <= '0;
      pr_q       <= '0;
      pe_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      pv_q       <= pv_d;
      pr_q       <= pr_d;
      pe_q       <= pe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Payload storage needs no reset: validity lives in the count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule
